instr_fetch_queue: RTL and testbench

- Instruction-side producer feeding the ID stage. Drives id_instr/id_pc/id_valid into decode and honours the decode-side id_stall.
- Generates sequential fetch PCs and issues requests on the SRAM-like instruction bus (req/addr_ok/data_ok).
- Buffers returned instructions in a small in-order queue.
- Flushes the queue and discards in-flight responses on a branch/jump/exception redirect.

---
 rtl/cpu_fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/instr_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_fetch_pkg;

    // Architectural boot address; the fetch queue defaults its reset PC to this.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // One fetched word with the PC it came from and its misaligned-fetch flag.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    // Bits needed to index a buffer of 'depth' entries.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold an occupancy count from 0 to 'depth' inclusive.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop and flush.
// A pop and a push in the same cycle are both honoured, even when full.
module fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               pushData_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [cntWidth(DEPTH)-1:0] count_o,
    output logic                       headValid_o,
    output fetch_entry_t               head_o
);

    localparam int PW = ptrWidth(DEPTH);
    localparam int CW = cntWidth(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          doPush;
    logic          doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Work out which operations really happen and the resulting pointers/count.
    always_comb begin
        doPop   = pop_i & (count_q != '0);
        doPush  = push_i & ((count_q != CW'(DEPTH)) | doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = nextPtr(wrPtr_q);
            if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
            if (doPush & ~doPop)      count_d = count_q + CW'(1);
            else if (doPop & ~doPush) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers; reset leaves the FIFO empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (doPush & ~flush_i) mem_q[wrPtr_q] <= pushData_i;
    end

    assign count_o     = count_q;
    assign headValid_o = (count_q != '0);
    assign head_o      = mem_q[rdPtr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues sequential fetches on the SRAM-like
// bus, buffers returned words in order and presents them to decode.
// A redirect flushes the buffer and arranges for in-flight responses to be
// dropped. The pending-PC FIFO occupancy doubles as the outstanding count.
module instr_fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        id_adel_o
);

    localparam int CW = cntWidth(DEPTH);
    localparam int OW = cntWidth(MAX_OUTSTANDING);

    logic [31:0]  fetchPc_q, fetchPc_d;
    logic [OW-1:0] dropCnt_q, dropCnt_d;
    logic         halted_q, halted_d;

    logic [CW-1:0] queueCount;
    logic          queueHeadValid;
    fetch_entry_t  queueHead;
    logic          queuePush;
    logic          queuePop;
    fetch_entry_t  queuePushData;

    logic [OW-1:0] outstanding;
    logic          pendHeadValid;
    fetch_entry_t  pendHead;
    fetch_entry_t  pendPushData;
    fetch_entry_t  respEntry;

    logic          pcAligned;
    logic [31:0]   occupancy;
    logic          addrFire;
    logic          dataFire;
    logic          dropResp;
    logic          misalignedPush;

    // Request gating, handshake decode and next-state for PC, drop count and halt.
    always_comb begin
        pcAligned  = (fetchPc_q[1:0] == 2'b00);
        occupancy  = 32'(queueCount) + 32'(outstanding) - 32'(dropCnt_q);
        inst_req_o = ~rst & ~redirect_i & ~halted_q & pcAligned
                   & (32'(outstanding) < MAX_OUTSTANDING)
                   & (occupancy < DEPTH);
        addrFire   = inst_req_o & inst_addr_ok_i;
        dataFire   = inst_data_ok_i & pendHeadValid;
        dropResp   = dataFire & (dropCnt_q != '0);
        misalignedPush = ~redirect_i & ~halted_q & ~pcAligned
                       & (outstanding == '0) & (32'(queueCount) < DEPTH);

        pendPushData       = '0;
        pendPushData.pc    = fetchPc_q;

        respEntry          = pendHead;
        respEntry.instr    = inst_rdata_i;
        respEntry.adel     = 1'b0;

        queuePushData = respEntry;
        if (misalignedPush) begin
            queuePushData.pc    = fetchPc_q;
            queuePushData.instr = 32'h0;
            queuePushData.adel  = 1'b1;
        end
        queuePush = ~redirect_i & ((dataFire & ~dropResp) | misalignedPush);
        queuePop  = queueHeadValid & ~id_stall_i & ~redirect_i;

        fetchPc_d = fetchPc_q;
        dropCnt_d = dropCnt_q;
        halted_d  = halted_q;
        if (redirect_i) begin
            fetchPc_d = redirect_pc_i;
            dropCnt_d = outstanding - OW'(dataFire);
            halted_d  = 1'b0;
        end else begin
            if (addrFire)       fetchPc_d = fetchPc_q + 32'd4;
            if (dropResp)       dropCnt_d = dropCnt_q - OW'(1);
            if (misalignedPush) halted_d  = 1'b1;
        end
    end

    // Fetch PC, pending-drop count and halt flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc_q <= RESET_PC;
            dropCnt_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            fetchPc_q <= fetchPc_d;
            dropCnt_q <= dropCnt_d;
            halted_q  <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_pending (
        .clk        (clk),
        .rst        (rst),
        .push_i     (addrFire),
        .pushData_i (pendPushData),
        .pop_i      (dataFire),
        .flush_i    (1'b0),
        .count_o    (outstanding),
        .headValid_o(pendHeadValid),
        .head_o     (pendHead)
    );

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (queuePush),
        .pushData_i (queuePushData),
        .pop_i      (queuePop),
        .flush_i    (redirect_i),
        .count_o    (queueCount),
        .headValid_o(queueHeadValid),
        .head_o     (queueHead)
    );

    assign inst_addr_o = fetchPc_q;
    assign id_valid_o  = queueHeadValid;
    assign id_pc_o     = queueHeadValid ? queueHead.pc : 32'h0;
    assign id_instr_o  = (queueHeadValid & ~queueHead.adel) ? queueHead.instr : 32'h0;
    assign id_adel_o   = queueHeadValid & queueHead.adel;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a behavioural bus and a
// queue-level reference model built from the architectural rules.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] BOOT = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_stall_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_adel_o;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(BOOT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req_o    (inst_req_o),
        .inst_addr_o   (inst_addr_o),
        .inst_addr_ok_i(inst_addr_ok_i),
        .inst_data_ok_i(inst_data_ok_i),
        .inst_rdata_i  (inst_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_stall_i    (id_stall_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_adel_o     (id_adel_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } expEntry_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } busReq_t;

    expEntry_t   mQ[$];
    busReq_t     busQ[$];
    logic [31:0] mPc;
    logic        mHalted;
    int          epoch;
    int          compared;
    int          mismatched;
    string       curTest;

    // The bus returns a word derived from the address so misrouted data is visible.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    // Requests accepted since the latest redirect will be delivered; older ones are dropped.
    function automatic int liveOutstanding();
        int n = 0;
        foreach (busQ[i]) if (busQ[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic modelReset();
        mQ.delete();
        busQ.delete();
        mPc     = BOOT;
        mHalted = 1'b0;
        epoch   = 0;
    endtask

    // One clock: drive inputs at the falling edge, compare, then advance the model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic stall,
                        input logic aOk, input logic dAllow);
        logic      expReq, dOk, expValid, deliver, mis;
        busReq_t   r;
        expEntry_t h;
        @(negedge clk);
        dOk            = dAllow && (busQ.size() != 0);
        redirect_i     = redir;
        redirect_pc_i  = rpc;
        id_stall_i     = stall;
        inst_addr_ok_i = aOk;
        inst_data_ok_i = dOk;
        inst_rdata_i   = dOk ? instrOf(busQ[0].addr) : 32'hDEAD_BEEF;
        #2;
        expValid = (mQ.size() != 0);
        expReq   = !redir && !mHalted && (mPc[1:0] == 2'b00) && (busQ.size() < MAXO)
                   && ((mQ.size() + liveOutstanding()) < DEPTH);
        mis      = !redir && !mHalted && (mPc[1:0] != 2'b00) && (busQ.size() == 0)
                   && (mQ.size() < DEPTH);

        compared++;
        if (id_valid_o !== expValid) begin
            mismatched++;
            $display("[TB] FAIL %s id_valid t=%0t got %b want %b", curTest, $time, id_valid_o, expValid);
        end
        if (expValid) begin
            h = mQ[0];
            compared++;
            if (id_pc_o !== h.pc) begin
                mismatched++;
                $display("[TB] FAIL %s id_pc t=%0t got %h want %h", curTest, $time, id_pc_o, h.pc);
            end
            compared++;
            if (id_instr_o !== h.instr) begin
                mismatched++;
                $display("[TB] FAIL %s id_instr t=%0t got %h want %h", curTest, $time, id_instr_o, h.instr);
            end
            compared++;
            if (id_adel_o !== h.adel) begin
                mismatched++;
                $display("[TB] FAIL %s id_adel t=%0t got %b want %b", curTest, $time, id_adel_o, h.adel);
            end
        end else begin
            compared++;
            if (id_instr_o !== 32'h0 || id_adel_o !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL %s idle_head t=%0t got instr %h adel %b want 0/0", curTest, $time, id_instr_o, id_adel_o);
            end
        end
        compared++;
        if (inst_req_o !== expReq) begin
            mismatched++;
            $display("[TB] FAIL %s inst_req t=%0t got %b want %b", curTest, $time, inst_req_o, expReq);
        end
        compared++;
        if (inst_addr_o !== mPc) begin
            mismatched++;
            $display("[TB] FAIL %s inst_addr t=%0t got %h want %h", curTest, $time, inst_addr_o, mPc);
        end

        deliver = 1'b0;
        if (dOk) begin
            r       = busQ.pop_front();
            deliver = (r.epoch == epoch) && !redir;
        end
        if (expReq && aOk) begin
            busQ.push_back('{addr: mPc, epoch: epoch});
            mPc = mPc + 32'd4;
        end
        if (redir) begin
            mQ.delete();
            mPc     = rpc;
            mHalted = 1'b0;
            epoch++;
        end else begin
            if (expValid && !stall) void'(mQ.pop_front());
            if (deliver) mQ.push_back('{pc: r.addr, instr: instrOf(r.addr), adel: 1'b0});
            if (mis) begin
                mQ.push_back('{pc: mPc, instr: 32'h0, adel: 1'b1});
                mHalted = 1'b1;
            end
        end
    endtask

    task automatic runResponsive(input int n, input logic stall);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, stall, 1'b1, 1'b1);
    endtask

    // Accept requests while withholding responses until two are in flight (bounded).
    task automatic reachTwoOutstanding();
        for (int i = 0; i < 10 && busQ.size() < MAXO; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        curTest = "reset";
        #1;
        compared++;
        if ({inst_req_o, id_valid_o, id_adel_o} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset flags got req %b valid %b adel %b want 0", inst_req_o, id_valid_o, id_adel_o);
        end
        compared++;
        if (id_instr_o !== 32'h0 || id_pc_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset head got %h/%h want 0/0", id_instr_o, id_pc_o);
        end
        compared++;
        if (inst_addr_o !== BOOT) begin
            mismatched++;
            $display("[TB] FAIL reset addr got %h want %h", inst_addr_o, BOOT);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_sequential();
        curTest = "sequential";
        runResponsive(12, 1'b0);
    endtask

    task automatic test_stall();
        curTest = "stall";
        runResponsive(10, 1'b1);
        runResponsive(8, 1'b0);
    endtask

    task automatic test_redirect();
        curTest = "redirect";
        reachTwoOutstanding();
        step(1'b1, 32'h8000_0100, 1'b0, 1'b1, 1'b0);
        runResponsive(8, 1'b0);
    endtask

    task automatic test_redirect_same_cycle();
        curTest = "redirect_data_ok";
        reachTwoOutstanding();
        step(1'b1, 32'h8000_0180, 1'b0, 1'b1, 1'b1);
        runResponsive(8, 1'b0);
    endtask

    task automatic test_misaligned();
        curTest = "misaligned";
        step(1'b1, 32'h8000_0102, 1'b0, 1'b1, 1'b1);
        runResponsive(5, 1'b1);
        runResponsive(3, 1'b0);
        step(1'b1, 32'h8000_0200, 1'b0, 1'b1, 1'b1);
        runResponsive(8, 1'b0);
    endtask

    task automatic test_wrap();
        curTest = "wrap";
        step(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
        runResponsive(8, 1'b0);
    endtask

    task automatic test_async_reset();
        curTest = "async_reset";
        reachTwoOutstanding();
        @(negedge clk);
        #1;
        rst            = 1'b1;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        redirect_i     = 1'b0;
        #1;
        compared++;
        if ({inst_req_o, id_valid_o, id_adel_o} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL async_reset flags got req %b valid %b adel %b want 0", inst_req_o, id_valid_o, id_adel_o);
        end
        compared++;
        if (id_instr_o !== 32'h0 || id_pc_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL async_reset head got %h/%h want 0/0", id_instr_o, id_pc_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        runResponsive(8, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        curTest = "random";
        for (int i = 0; i < 400; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 5) != 0) rpc[1:0] = 2'b00;
            step(($urandom_range(0, 24) == 0), rpc, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
    endtask

    initial begin
        rst            = 1'b1;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        id_stall_i     = 1'b0;
        compared       = 0;
        mismatched     = 0;
        modelReset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
